// File: rtl/snd_mix_pwm.sv
// Multi-channel sound mixer: per-channel volume and mute, saturating sum, 1-bit PWM DAC.
// Define SND_SIGMA_DELTA_EN to swap the PWM comparator for a first-order delta-sigma modulator.
//
//  state    | meaning
//  ST_IDLE  | ready, waiting for a valid sample set
//  ST_MUL   | captured set being scaled per channel
//  ST_SUM   | products summed, saturated and written to mix_out
module snd_mix_pwm #(
    parameter int NCH      = 4,
    parameter int SW       = 16,
    parameter int VW       = 4,
    parameter int PWM_BITS = 10
) (
    input  logic                CLK_IN,
    input  logic                RST,
    input  logic                cen,
    input  logic [NCH*SW-1:0]   snd_in,
    input  logic                snd_valid,
    output logic                snd_ready,
    input  logic [NCH*VW-1:0]   vol,
    input  logic [NCH-1:0]      mute,
    output logic [SW-1:0]       mix_out,
    output logic                clip,
    output logic                snd_sample,
    output logic                snd_pwm
);

    localparam int PW   = SW + VW + 1;
    localparam int NW   = $clog2(NCH);
    localparam int SUMW = SW + VW + NW + 1;

    localparam logic signed [SUMW-1:0] SAT_MAX = {{(SUMW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [SUMW-1:0] SAT_MIN = {{(SUMW-SW+1){1'b1}}, {(SW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SUM  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic [NCH*SW-1:0]      in_q, in_d;
    logic [NCH*VW-1:0]      vol_q, vol_d;
    logic [NCH-1:0]         mute_q, mute_d;
    logic signed [PW-1:0]   prod_q [NCH];
    logic signed [PW-1:0]   prod_d [NCH];
    logic [SW-1:0]          mix_q, mix_d;
    logic                   clip_q, clip_d;
    logic signed [SUMW-1:0] sum_c;
    logic signed [SUMW-1:0] shift_c;

    logic [PWM_BITS-1:0]    cnt_q, cnt_d;
    logic [PWM_BITS-1:0]    duty_q, duty_d;
    logic                   sample_q, sample_d;
    logic                   pwm_q, pwm_d;
    logic                   wrap_c;
    logic [SW-1:0]          mix_ob_c;
`ifdef SND_SIGMA_DELTA_EN
    logic [PWM_BITS-1:0]    acc_q, acc_d;
    logic [PWM_BITS:0]      acc_sum_c;
`endif

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        in_d    = in_q;
        vol_d   = vol_q;
        mute_d  = mute_q;
        prod_d  = prod_q;
        mix_d   = mix_q;
        clip_d  = clip_q;

        sum_c = '0;
        for (int k = 0; k < NCH; k++) begin
            sum_c = sum_c + SUMW'(prod_q[k]);
        end
        shift_c = sum_c >>> VW;

        case (state_q)
            ST_IDLE: begin
                if (snd_valid && ready_q) begin
                    in_d    = snd_in;
                    vol_d   = vol;
                    mute_d  = mute;
                    ready_d = 1'b0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                // Volume is unsigned; a zero MSB keeps it positive in the signed multiply.
                for (int k = 0; k < NCH; k++) begin
                    prod_d[k] = mute_q[k] ? '0 :
                                PW'($signed(in_q[k*SW +: SW])) *
                                PW'($signed({1'b0, vol_q[k*VW +: VW]}));
                end
                state_d = ST_SUM;
            end
            ST_SUM: begin
                if (shift_c > SAT_MAX) begin
                    mix_d  = {1'b0, {(SW-1){1'b1}}};
                    clip_d = 1'b1;
                end else if (shift_c < SAT_MIN) begin
                    mix_d  = {1'b1, {(SW-1){1'b0}}};
                    clip_d = 1'b1;
                end else begin
                    mix_d  = shift_c[SW-1:0];
                    clip_d = 1'b0;
                end
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Duty loads from the pre-edge mix_out, so a mix landing on the wrap edge waits a period.
    always_comb begin
        wrap_c   = cen && (&cnt_q);
        mix_ob_c = mix_q ^ {1'b1, {(SW-1){1'b0}}};
        cnt_d    = cen ? cnt_q + PWM_BITS'(1) : cnt_q;
        duty_d   = wrap_c ? mix_ob_c[SW-1 -: PWM_BITS] : duty_q;
        sample_d = wrap_c;
`ifdef SND_SIGMA_DELTA_EN
        acc_sum_c = {1'b0, acc_q} + {1'b0, duty_d};
        acc_d     = cen ? acc_sum_c[PWM_BITS-1:0] : acc_q;
        pwm_d     = cen ? acc_sum_c[PWM_BITS] : pwm_q;
`else
        pwm_d     = cen ? (cnt_d < duty_d) : pwm_q;
`endif
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            in_q     <= '0;
            vol_q    <= '0;
            mute_q   <= '0;
            for (int k = 0; k < NCH; k++) begin
                prod_q[k] <= '0;
            end
            mix_q    <= '0;
            clip_q   <= 1'b0;
            cnt_q    <= '0;
            duty_q   <= {1'b1, {(PWM_BITS-1){1'b0}}};
            sample_q <= 1'b0;
            pwm_q    <= 1'b0;
`ifdef SND_SIGMA_DELTA_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            in_q     <= in_d;
            vol_q    <= vol_d;
            mute_q   <= mute_d;
            prod_q   <= prod_d;
            mix_q    <= mix_d;
            clip_q   <= clip_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            sample_q <= sample_d;
            pwm_q    <= pwm_d;
`ifdef SND_SIGMA_DELTA_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign snd_ready  = ready_q;
    assign mix_out    = mix_q;
    assign clip       = clip_q;
    assign snd_sample = sample_q;
    assign snd_pwm    = pwm_q;

endmodule

// File: tb/tb_snd_mix_pwm.sv
// Self-checking bench for snd_mix_pwm against an arithmetic model of the mix and duty rules.
module tb_snd_mix_pwm;

    logic        CLK_IN = 1'b0;
    logic        RST = 1'b0;
    logic        cen = 1'b1;
    logic [63:0] snd_in = '0;
    logic        snd_valid = 1'b0;
    logic        snd_ready;
    logic [15:0] vol = '0;
    logic [3:0]  mute = '0;
    logic [15:0] mix_out;
    logic        clip;
    logic        snd_sample;
    logic        snd_pwm;

    int n_tests = 0;
    int n_fail  = 0;

    snd_mix_pwm #(.NCH(4), .SW(16), .VW(4), .PWM_BITS(10)) dut (
        .CLK_IN(CLK_IN), .RST(RST), .cen(cen),
        .snd_in(snd_in), .snd_valid(snd_valid), .snd_ready(snd_ready),
        .vol(vol), .mute(mute),
        .mix_out(mix_out), .clip(clip),
        .snd_sample(snd_sample), .snd_pwm(snd_pwm)
    );

    always #5 CLK_IN = ~CLK_IN;

    function automatic void model_mix(input logic [63:0] din, input logic [15:0] dv,
                                      input logic [3:0] dm, output logic [15:0] mx,
                                      output logic cl);
        longint s = 0;
        longint m;
        for (int k = 0; k < 4; k++) begin
            if (!dm[k]) s += longint'($signed(din[k*16 +: 16])) * longint'(dv[k*4 +: 4]);
        end
        m = s >>> 4;
        if (m > 32767) begin
            mx = 16'h7FFF; cl = 1'b1;
        end else if (m < -32768) begin
            mx = 16'h8000; cl = 1'b1;
        end else begin
            mx = m[15:0]; cl = 1'b0;
        end
    endfunction

    function automatic int duty_of(input logic [15:0] mx);
        return (int'($signed(mx)) + 32768) / 64;
    endfunction

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    // Leaves the bench one step after the acceptance edge.
    task automatic send_set(input logic [63:0] din, input logic [15:0] dv, input logic [3:0] dm);
        int w;
        snd_in = din; vol = dv; mute = dm; snd_valid = 1'b1;
        w = 0;
        while (!snd_ready && w < 10) begin
            tick();
            w++;
        end
        if (!snd_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_ready_timeout: snd_ready=%0b required 1", snd_ready);
        end
        tick();
        snd_valid = 1'b0;
    endtask

    // Starts at the next snd_sample (or the current one); counts high samples over one period.
    task automatic measure_period(output int highs, output int len, output int adj);
        int w;
        logic prev;
        highs = 0; len = -1; adj = 0;
        w = 0;
        while (!snd_sample && w < 2100) begin
            tick();
            w++;
        end
        if (!snd_sample) return;
        highs = int'(snd_pwm);
        prev = snd_pwm;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (snd_sample) begin
                len = i;
                break;
            end
            highs += int'(snd_pwm);
            if (prev && snd_pwm) adj++;
            prev = snd_pwm;
        end
    endtask

    task automatic test_reset();
        int first;
        int h, l, a;
        RST = 1'b0; cen = 1'b1; snd_valid = 1'b0; snd_in = '0; vol = '0; mute = '0;
        repeat (10) tick();
        n_tests++; if (snd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", snd_ready); end
        n_tests++; if (mix_out !== 16'h0) begin n_fail++; $display("FAIL reset_mix: got %04h required 0000", mix_out); end
        n_tests++; if (clip !== 1'b0) begin n_fail++; $display("FAIL reset_clip: got %0b required 0", clip); end
        n_tests++; if (snd_sample !== 1'b0) begin n_fail++; $display("FAIL reset_sample: got %0b required 0", snd_sample); end
        n_tests++; if (snd_pwm !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %0b required 0", snd_pwm); end
        RST = 1'b1;
        first = -1;
        for (int c = 1; c <= 2000; c++) begin
            tick();
            if (snd_sample) begin
                first = c;
                break;
            end
        end
        n_tests++; if (first != 1024) begin n_fail++; $display("FAIL reset_first_sample: got %0d cycles required 1024", first); end
        measure_period(h, l, a);
        n_tests++; if (h != 512) begin n_fail++; $display("FAIL reset_midscale_highs: got %0d required 512", h); end
        n_tests++; if (l != 1024) begin n_fail++; $display("FAIL reset_period: got %0d required 1024", l); end
    endtask

    task automatic test_gain();
        logic [63:0] din;
        logic [15:0] exp_mx;
        logic        exp_cl;
        int h, l, a;
        din = {$urandom(), $urandom()};
        din[15:0] = 16'h4000;
        model_mix(din, {12'($urandom()), 4'd15}, 4'b1110, exp_mx, exp_cl);
        send_set(din, {12'($urandom()), 4'd15}, 4'b1110);
        n_tests++; if (snd_ready !== 1'b0) begin n_fail++; $display("FAIL gain_busy1: got %0b required 0", snd_ready); end
        tick();
        n_tests++; if (snd_ready !== 1'b0) begin n_fail++; $display("FAIL gain_busy2: got %0b required 0", snd_ready); end
        n_tests++; if (mix_out !== 16'h0) begin n_fail++; $display("FAIL gain_early_mix: got %04h required 0000", mix_out); end
        tick();
        n_tests++; if (snd_ready !== 1'b1) begin n_fail++; $display("FAIL gain_ready_back: got %0b required 1", snd_ready); end
        n_tests++; if (mix_out !== exp_mx) begin n_fail++; $display("FAIL gain_mix: got %04h required %04h", mix_out, exp_mx); end
        n_tests++; if (clip !== exp_cl) begin n_fail++; $display("FAIL gain_clip: got %0b required %0b", clip, exp_cl); end
        measure_period(h, l, a);
        n_tests++; if (h != duty_of(exp_mx)) begin n_fail++; $display("FAIL gain_highs: got %0d required %0d", h, duty_of(exp_mx)); end
        n_tests++; if (l != 1024) begin n_fail++; $display("FAIL gain_period: got %0d required 1024", l); end
    endtask

    task automatic test_saturation();
        logic [63:0] din [3];
        logic [63:0] rin;
        logic [15:0] rv;
        logic [3:0]  rm;
        logic [15:0] exp_mx;
        logic        exp_cl;
        int h, l, a;
        din[0] = {4{16'h7FFF}};
        din[1] = {4{16'h8000}};
        din[2] = '0;
        for (int i = 0; i < 3; i++) begin
            model_mix(din[i], 16'hFFFF, 4'b0000, exp_mx, exp_cl);
            send_set(din[i], 16'hFFFF, 4'b0000);
            tick(); tick();
            n_tests++; if (mix_out !== exp_mx) begin n_fail++; $display("FAIL sat_mix_%0d: got %04h required %04h", i, mix_out, exp_mx); end
            n_tests++; if (clip !== exp_cl) begin n_fail++; $display("FAIL sat_clip_%0d: got %0b required %0b", i, clip, exp_cl); end
            if (i == 1) begin
                measure_period(h, l, a);
                n_tests++; if (h != 0) begin n_fail++; $display("FAIL sat_neg_highs: got %0d required 0", h); end
                n_tests++; if (l != 1024) begin n_fail++; $display("FAIL sat_neg_period: got %0d required 1024", l); end
            end
        end
        for (int i = 0; i < 16; i++) begin
            rin = {$urandom(), $urandom()};
            rv  = 16'($urandom());
            rm  = 4'($urandom());
            model_mix(rin, rv, rm, exp_mx, exp_cl);
            send_set(rin, rv, rm);
            tick(); tick();
            n_tests++; if (mix_out !== exp_mx) begin n_fail++; $display("FAIL rand_mix_%0d: got %04h required %04h", i, mix_out, exp_mx); end
            n_tests++; if (clip !== exp_cl) begin n_fail++; $display("FAIL rand_clip_%0d: got %0b required %0b", i, clip, exp_cl); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] b_in [3];
        logic [15:0] b_v [3];
        logic [3:0]  b_m [3];
        logic [15:0] e_mx [3];
        logic        e_cl [3];
        int acc_c [3];
        int n, nchk;
        logic rdy, v;
        for (int i = 0; i < 3; i++) begin
            b_in[i] = {$urandom(), $urandom()};
            b_v[i]  = 16'($urandom());
            b_m[i]  = 4'($urandom());
            model_mix(b_in[i], b_v[i], b_m[i], e_mx[i], e_cl[i]);
            acc_c[i] = -100;
        end
        n = 0; nchk = 0;
        snd_in = b_in[0]; vol = b_v[0]; mute = b_m[0]; snd_valid = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            rdy = snd_ready; v = snd_valid;
            tick();
            if (rdy && v) begin
                acc_c[n] = cyc;
                n++;
                if (n < 3) begin
                    snd_in = b_in[n]; vol = b_v[n]; mute = b_m[n];
                end else begin
                    snd_valid = 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (k < n && acc_c[k] + 2 == cyc) begin
                    nchk++;
                    n_tests++; if (mix_out !== e_mx[k]) begin n_fail++; $display("FAIL b2b_mix_%0d: got %04h required %04h", k, mix_out, e_mx[k]); end
                end
            end
        end
        snd_valid = 1'b0;
        n_tests++; if (n != 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d required 3", n); end
        n_tests++; if (nchk != 3) begin n_fail++; $display("FAIL b2b_mix_checks: got %0d required 3", nchk); end
        n_tests++; if (acc_c[1] - acc_c[0] != 3) begin n_fail++; $display("FAIL b2b_gap_ab: got %0d required 3", acc_c[1] - acc_c[0]); end
        n_tests++; if (acc_c[2] - acc_c[1] != 3) begin n_fail++; $display("FAIL b2b_gap_bc: got %0d required 3", acc_c[2] - acc_c[1]); end
    endtask

    task automatic test_collision_and_cen();
        logic [63:0] xin, yin;
        logic [15:0] x_mx, y_mx;
        logic        x_cl, y_cl;
        int h, l, a, w, c, frz_bad;
        logic frozen;
        xin = 64'h0000_0000_0000_4000;
        yin = 64'h0000_0000_0000_C000;
        model_mix(xin, 16'h000F, 4'b1110, x_mx, x_cl);
        model_mix(yin, 16'h0008, 4'b1110, y_mx, y_cl);
        send_set(xin, 16'h000F, 4'b1110);
        tick(); tick();
        w = 0;
        while (!snd_sample && w < 2100) begin
            tick();
            w++;
        end
        repeat (1021) tick();
        send_set(yin, 16'h0008, 4'b1110);
        measure_period(h, l, a);
        n_tests++; if (h != duty_of(x_mx)) begin n_fail++; $display("FAIL coll_old_duty: got %0d required %0d", h, duty_of(x_mx)); end
        n_tests++; if (mix_out !== y_mx) begin n_fail++; $display("FAIL coll_mix: got %04h required %04h", mix_out, y_mx); end
        measure_period(h, l, a);
        n_tests++; if (h != duty_of(y_mx)) begin n_fail++; $display("FAIL coll_new_duty: got %0d required %0d", h, duty_of(y_mx)); end
        n_tests++; if (l != 1024) begin n_fail++; $display("FAIL coll_period: got %0d required 1024", l); end

        // At a period start now, duty from y_mx.
        h = int'(snd_pwm);
        for (int i = 1; i <= 300; i++) begin
            tick();
            h += int'(snd_pwm);
        end
        cen = 1'b0;
        frozen = snd_pwm;
        frz_bad = 0;
        repeat (50) begin
            tick();
            if (snd_pwm !== frozen || snd_sample !== 1'b0) frz_bad++;
        end
        n_tests++; if (frz_bad != 0) begin n_fail++; $display("FAIL cen_freeze: got %0d changed cycles required 0", frz_bad); end
        cen = 1'b1;
        c = -1;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (snd_sample) begin
                c = i;
                break;
            end
            h += int'(snd_pwm);
        end
        n_tests++; if (c != 724) begin n_fail++; $display("FAIL cen_resume_wrap: got %0d cycles required 724", c); end
        n_tests++; if (h != duty_of(y_mx)) begin n_fail++; $display("FAIL cen_highs: got %0d required %0d", h, duty_of(y_mx)); end
    endtask

    task automatic test_duty_quarter();
        logic [63:0] din;
        logic [15:0] exp_mx;
        logic        exp_cl;
        int h, l, a;
        din = {$urandom(), 16'hC000, 16'hC000};
        model_mix(din, 16'h0088, 4'b1100, exp_mx, exp_cl);
        send_set(din, 16'h0088, 4'b1100);
        tick(); tick();
        n_tests++; if (mix_out !== exp_mx) begin n_fail++; $display("FAIL quarter_mix: got %04h required %04h", mix_out, exp_mx); end
        measure_period(h, l, a);
        n_tests++; if (h != duty_of(exp_mx)) begin n_fail++; $display("FAIL quarter_highs: got %0d required %0d", h, duty_of(exp_mx)); end
        n_tests++; if (l != 1024) begin n_fail++; $display("FAIL quarter_period: got %0d required 1024", l); end
`ifdef SND_SIGMA_DELTA_EN
        n_tests++; if (a != 0) begin n_fail++; $display("FAIL sd_adjacent_ones: got %0d required 0", a); end
`endif
    endtask

    task automatic test_reset_inflight();
        send_set(64'h0000_0000_0000_4000, 16'h000F, 4'b1110);
        tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        n_tests++; if (mix_out !== 16'h0) begin n_fail++; $display("FAIL inflight_mix: got %04h required 0000", mix_out); end
        n_tests++; if (snd_ready !== 1'b1) begin n_fail++; $display("FAIL inflight_ready: got %0b required 1", snd_ready); end
        repeat (3) tick();
        n_tests++; if (mix_out !== 16'h0) begin n_fail++; $display("FAIL inflight_late_mix: got %04h required 0000", mix_out); end
        n_tests++; if (clip !== 1'b0) begin n_fail++; $display("FAIL inflight_clip: got %0b required 0", clip); end
    endtask

    initial begin
        test_reset();
        test_gain();
        test_saturation();
        test_back_to_back();
        test_collision_and_cen();
        test_duty_quarter();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
